// File: rtl/cpu_pkg.sv
// Shared types and defaults for the interrupt controller slice: FSM state
// encoding, default vector map and the vector-id width helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SERV,
    NREQ,
    NSERV
  } state_t;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0080;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;
  localparam logic [31:0] NMI_VEC_DEF    = 32'h0000_0040;

  // Width of an irq id; a single line still needs one bit to carry the id.
  function automatic int IRQ_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Source/Controller-side signal bundle of the interrupt controller.
// slave = controller block, master = sources plus processor Controller.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 8
);
  localparam int ID_W = cpu_pkg::IRQ_ID_W(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq;
  logic               nmi;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               INT;
  logic               NMI;
  logic               INA;
  logic               INTD;
  logic [ID_W-1:0]    vec_id;
  logic [31:0]        vec_addr;
  logic               busy;

  modport master (
    output irq, nmi, mask_we, mask_wdata, INA, INTD,
    input  INT, NMI, vec_id, vec_addr, busy
  );

  modport slave (
    input  irq, nmi, mask_we, mask_wdata, INA, INTD,
    output INT, NMI, vec_id, vec_addr, busy
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 is the most urgent request.
module irq_prio_enc
  import cpu_pkg::*;
#(
  parameter int N = 8,
  parameter int W = IRQ_ID_W(N)
) (
  input  logic [N-1:0] pend,
  output logic [W-1:0] sel,
  output logic         any
);

  always_comb begin
    sel = '0;
    any = |pend;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) sel = W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Masks/prioritises maskable irqs plus one NMI and runs the INA/INTD handshake.
// Build option IRQ_EDGE_EN: rising-edge sticky irq pending bits instead of levels.
module interrupt_controller
  import cpu_pkg::*;
#(
  parameter int                 NUM_IRQ    = 8,
  parameter logic [31:0]        VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0]        VEC_STRIDE = VEC_STRIDE_DEF,
  parameter logic [31:0]        NMI_VEC    = NMI_VEC_DEF,
  parameter logic [NUM_IRQ-1:0] MASK_RST   = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  interrupt_controller_if.slave bus
);

  localparam int W = IRQ_ID_W(NUM_IRQ);

  state_t             state_reg, state_next;
  logic [W-1:0]       vec_id_reg, vec_id_next;
  logic               nested_reg, nested_next;
  logic               nmi_prev_reg;
  logic               nmi_pend_reg, nmi_pend_next;
  logic [NUM_IRQ-1:0] mask_reg;
  logic               int_reg, nmi_out_reg, busy_reg;
  logic [31:0]        vec_addr_reg, vec_addr_next;

  logic [NUM_IRQ-1:0] pend;
  logic [W-1:0]       sel;
  logic               any;
  logic               nmi_edge;
  logic               nmi_req;
  logic               ina_irq;

  assign nmi_edge = bus.nmi & ~nmi_prev_reg;
  // A fresh edge is acted on in the cycle it is seen, keeping latency at one edge.
  assign nmi_req  = nmi_pend_reg | nmi_edge;

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_prev_reg;
  logic [NUM_IRQ-1:0] sticky_reg;
  logic [NUM_IRQ-1:0] irq_rise;

  assign irq_rise = bus.irq & ~irq_prev_reg;
  assign pend     = (sticky_reg | irq_rise) & mask_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_prev_reg <= '0;
    else     irq_prev_reg <= bus.irq;
  end

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sticky
    // A new edge wins over an acknowledge of the same line in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        sticky_reg[gi] <= 1'b0;
      else if (irq_rise[gi])
        sticky_reg[gi] <= 1'b1;
      else if (ina_irq && (vec_id_reg == W'(gi)))
        sticky_reg[gi] <= 1'b0;
    end
  end
`else
  assign pend = bus.irq & mask_reg;
`endif

  irq_prio_enc #(
    .N (NUM_IRQ),
    .W (W)
  ) u_prio_enc (
    .pend (pend),
    .sel  (sel),
    .any  (any)
  );

  always_comb begin
    state_next  = state_reg;
    vec_id_next = vec_id_reg;
    nested_next = nested_reg;
    ina_irq     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (nmi_req) begin
          state_next = NREQ;
        end else if (any) begin
          state_next  = REQ;
          vec_id_next = sel;
        end
      end
      REQ: begin
        if (bus.INA) begin
          state_next = SERV;
          ina_irq    = 1'b1;
        end else if (nmi_req) begin
          state_next = NREQ;
        end else if (!pend[vec_id_reg]) begin
          state_next = IDLE;
        end else begin
          // pend[vec_id] is still set, so sel can only move to a more urgent line.
          vec_id_next = sel;
        end
      end
      SERV: begin
        if (bus.INTD) begin
          state_next = IDLE;
        end else if (nmi_req) begin
          state_next  = NREQ;
          nested_next = 1'b1;
        end
      end
      NREQ: begin
        if (bus.INA) state_next = NSERV;
      end
      NSERV: begin
        if (bus.INTD) begin
          state_next  = nested_reg ? SERV : IDLE;
          nested_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    nmi_pend_next = nmi_req;
    if (state_reg == NREQ && bus.INA) nmi_pend_next = nmi_edge;
  end

  always_comb begin
    vec_addr_next = VEC_BASE + (32'(vec_id_next) * VEC_STRIDE);
    if (state_next == NREQ || state_next == NSERV) vec_addr_next = NMI_VEC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      vec_id_reg   <= '0;
      nested_reg   <= 1'b0;
      nmi_prev_reg <= 1'b0;
      nmi_pend_reg <= 1'b0;
      mask_reg     <= MASK_RST;
      int_reg      <= 1'b0;
      nmi_out_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      vec_addr_reg <= VEC_BASE;
    end else begin
      state_reg    <= state_next;
      vec_id_reg   <= vec_id_next;
      nested_reg   <= nested_next;
      nmi_prev_reg <= bus.nmi;
      nmi_pend_reg <= nmi_pend_next;
      if (bus.mask_we) mask_reg <= bus.mask_wdata;
      int_reg      <= (state_next == REQ);
      nmi_out_reg  <= (state_next == NREQ);
      busy_reg     <= (state_next != IDLE);
      vec_addr_reg <= vec_addr_next;
    end
  end

  assign bus.INT      = int_reg;
  assign bus.NMI      = nmi_out_reg;
  assign bus.busy     = busy_reg;
  assign bus.vec_id   = vec_id_reg;
  assign bus.vec_addr = vec_addr_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: one table row per clock cycle,
// plus a hand-written asynchronous-reset sequence.
module tb_interrupt_controller;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  interrupt_controller_if #(.NUM_IRQ(8)) bus ();

  interrupt_controller #(.NUM_IRQ(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  irq;
    logic        nmi;
    logic        mwe;
    logic [7:0]  mwd;
    logic        ina;
    logic        intd;
    logic        e_int;
    logic        e_nmi;
    logic        e_busy;
    logic [2:0]  e_vid;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic [7:0] irq, logic nmi, logic mwe,
                              logic [7:0] mwd, logic ina, logic intd, logic e_int,
                              logic e_nmi, logic e_busy, logic [2:0] e_vid,
                              logic [31:0] e_addr);
    vec_t v;
    v.name = name; v.irq = irq; v.nmi = nmi; v.mwe = mwe; v.mwd = mwd;
    v.ina = ina; v.intd = intd; v.e_int = e_int; v.e_nmi = e_nmi;
    v.e_busy = e_busy; v.e_vid = e_vid; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      bus.irq        = tbl[i].irq;
      bus.nmi        = tbl[i].nmi;
      bus.mask_we    = tbl[i].mwe;
      bus.mask_wdata = tbl[i].mwd;
      bus.INA        = tbl[i].ina;
      bus.INTD       = tbl[i].intd;
      @(posedge clk);
      #1;
      check({tbl[i].name, ".INT"},      32'(bus.INT),    32'(tbl[i].e_int));
      check({tbl[i].name, ".NMI"},      32'(bus.NMI),    32'(tbl[i].e_nmi));
      check({tbl[i].name, ".busy"},     32'(bus.busy),   32'(tbl[i].e_busy));
      check({tbl[i].name, ".vec_id"},   32'(bus.vec_id), 32'(tbl[i].e_vid));
      check({tbl[i].name, ".vec_addr"}, bus.vec_addr,    tbl[i].e_addr);
      $display("cycle %0d %-14s irq=%02h nmi=%0b ina=%0b intd=%0b -> INT=%0b NMI=%0b busy=%0b id=%0d addr=%08h",
               i, tbl[i].name, tbl[i].irq, tbl[i].nmi, tbl[i].ina, tbl[i].intd,
               bus.INT, bus.NMI, bus.busy, bus.vec_id, bus.vec_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.irq = '0; bus.nmi = 1'b0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.INA = 1'b0; bus.INTD = 1'b0;
    @(posedge clk); #1;
    check("rst.INT",      32'(bus.INT),      32'd0);
    check("rst.NMI",      32'(bus.NMI),      32'd0);
    check("rst.busy",     32'(bus.busy),     32'd0);
    check("rst.vec_id",   32'(bus.vec_id),   32'd0);
    check("rst.mask",     32'(dut.mask_reg), 32'hFF);
    rst = 1'b0;

`ifndef IRQ_EDGE_EN
    //         name            irq    nmi we  wd     ina intd INT NMI busy id  addr
    tbl.push_back(mk("idle",        8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 32'h80));
    tbl.push_back(mk("req2",        8'h24, 0, 0, 8'h00, 0, 0, 1, 0, 1, 2, 32'hA0));
    tbl.push_back(mk("ack2",        8'h24, 0, 0, 8'h00, 1, 0, 0, 0, 1, 2, 32'hA0));
    tbl.push_back(mk("serv2_hold",  8'h24, 0, 0, 8'h00, 0, 0, 0, 0, 1, 2, 32'hA0));
    tbl.push_back(mk("done2",       8'h24, 0, 0, 8'h00, 0, 1, 0, 0, 0, 2, 32'hA0));
    tbl.push_back(mk("rereq2",      8'h24, 0, 0, 8'h00, 0, 0, 1, 0, 1, 2, 32'hA0));
    tbl.push_back(mk("ack2b",       8'h24, 0, 0, 8'h00, 1, 0, 0, 0, 1, 2, 32'hA0));
    tbl.push_back(mk("done2b",      8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 2, 32'hA0));
    tbl.push_back(mk("req4",        8'h10, 0, 0, 8'h00, 0, 0, 1, 0, 1, 4, 32'hC0));
    tbl.push_back(mk("ack_old4",    8'h12, 0, 0, 8'h00, 1, 0, 0, 0, 1, 4, 32'hC0));
    tbl.push_back(mk("done4",       8'h12, 0, 0, 8'h00, 0, 1, 0, 0, 0, 4, 32'hC0));
    tbl.push_back(mk("req4b",       8'h10, 0, 0, 8'h00, 0, 0, 1, 0, 1, 4, 32'hC0));
    tbl.push_back(mk("prio_upd1",   8'h12, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 32'h90));
    tbl.push_back(mk("withdraw1",   8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 32'h90));
    tbl.push_back(mk("req3",        8'h08, 0, 0, 8'h00, 0, 0, 1, 0, 1, 3, 32'hB0));
    tbl.push_back(mk("mask_wr",     8'h08, 0, 1, 8'hF7, 0, 0, 1, 0, 1, 3, 32'hB0));
    tbl.push_back(mk("mask_wdraw",  8'h08, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3, 32'hB0));
    tbl.push_back(mk("masked_idle", 8'h08, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3, 32'hB0));
    tbl.push_back(mk("unmask",      8'h08, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 3, 32'hB0));
    tbl.push_back(mk("quiet",       8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3, 32'hB0));
    tbl.push_back(mk("req1",        8'h02, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 32'h90));
    tbl.push_back(mk("serv1",       8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 32'h90));
    tbl.push_back(mk("nest_nreq",   8'h02, 1, 0, 8'h00, 0, 0, 0, 1, 1, 1, 32'h40));
    tbl.push_back(mk("nreq_hold",   8'h02, 1, 0, 8'h00, 0, 0, 0, 1, 1, 1, 32'h40));
    tbl.push_back(mk("nserv",       8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 32'h40));
    tbl.push_back(mk("nest_ret",    8'h02, 0, 0, 8'h00, 0, 1, 0, 0, 1, 1, 32'h90));
    tbl.push_back(mk("serv1_done",  8'h02, 0, 0, 8'h00, 0, 1, 0, 0, 0, 1, 32'h90));
    tbl.push_back(mk("quiet2",      8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 32'h90));
    tbl.push_back(mk("req2c",       8'h04, 0, 0, 8'h00, 0, 0, 1, 0, 1, 2, 32'hA0));
    tbl.push_back(mk("serv2c",      8'h04, 0, 0, 8'h00, 1, 0, 0, 0, 1, 2, 32'hA0));
    tbl.push_back(mk("intd_nmi",    8'h00, 1, 0, 8'h00, 0, 1, 0, 0, 0, 2, 32'hA0));
    tbl.push_back(mk("nmi_after",   8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 1, 2, 32'h40));
    tbl.push_back(mk("nserv_c",     8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1, 2, 32'h40));
    tbl.push_back(mk("nret_idle",   8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 2, 32'hA0));
    tbl.push_back(mk("pulse5",      8'h20, 0, 0, 8'h00, 0, 0, 1, 0, 1, 5, 32'hD0));
    tbl.push_back(mk("pulse5_gone", 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 5, 32'hD0));
    tbl.push_back(mk("req0",        8'h01, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 32'h80));
    tbl.push_back(mk("req_to_nreq", 8'h01, 1, 0, 8'h00, 0, 0, 0, 1, 1, 0, 32'h40));
    tbl.push_back(mk("nserv_d",     8'h01, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 32'h40));
    tbl.push_back(mk("nret_flat",   8'h01, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 32'h80));
    tbl.push_back(mk("rearb0",      8'h01, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 32'h80));
    tbl.push_back(mk("withdraw0",   8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 32'h80));
    tbl.push_back(mk("stray_ina",   8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 32'h80));
    tbl.push_back(mk("stray_intd",  8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 32'h80));
`else
    //         name            irq    nmi we  wd     ina intd INT NMI busy id  addr
    tbl.push_back(mk("idle",        8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 32'h80));
    tbl.push_back(mk("pulse5",      8'h20, 0, 0, 8'h00, 0, 0, 1, 0, 1, 5, 32'hD0));
    tbl.push_back(mk("sticky5",     8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 1, 5, 32'hD0));
    tbl.push_back(mk("sticky5b",    8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 1, 5, 32'hD0));
    tbl.push_back(mk("ack5",        8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1, 5, 32'hD0));
    tbl.push_back(mk("done5",       8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 5, 32'hD0));
    tbl.push_back(mk("cleared5",    8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 5, 32'hD0));
    tbl.push_back(mk("edge3",       8'h08, 0, 0, 8'h00, 0, 0, 1, 0, 1, 3, 32'hB0));
    tbl.push_back(mk("mask_wr",     8'h00, 0, 1, 8'hF7, 0, 0, 1, 0, 1, 3, 32'hB0));
    tbl.push_back(mk("mask_wdraw",  8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3, 32'hB0));
    tbl.push_back(mk("unmask",      8'h00, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 3, 32'hB0));
    tbl.push_back(mk("rereq3",      8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 1, 3, 32'hB0));
    tbl.push_back(mk("ack3",        8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1, 3, 32'hB0));
    tbl.push_back(mk("done3",       8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3, 32'hB0));
`endif
    run_table();

    // Asynchronous reset while an NMI request is outstanding.
    bus.irq = '0; bus.INA = 1'b0; bus.INTD = 1'b0;
    bus.mask_we = 1'b1; bus.mask_wdata = 8'h0F;
    @(posedge clk); #1;
    bus.mask_we = 1'b0;
    check("arst.mask_pre", 32'(dut.mask_reg), 32'h0F);
    bus.nmi = 1'b1;
    @(posedge clk); #1;
    check("arst.NMI_pre", 32'(bus.NMI), 32'd1);
    $display("arst setup: NMI=%0b busy=%0b mask=%02h", bus.NMI, bus.busy, dut.mask_reg);
    #2;
    rst = 1'b1;
    #1;
    check("arst.NMI",      32'(bus.NMI),      32'd0);
    check("arst.busy",     32'(bus.busy),     32'd0);
    check("arst.mask",     32'(dut.mask_reg), 32'hFF);
    check("arst.vec_id",   32'(bus.vec_id),   32'd0);
    check("arst.vec_addr", bus.vec_addr,      32'h80);
    $display("arst mid-cycle: NMI=%0b busy=%0b mask=%02h", bus.NMI, bus.busy, dut.mask_reg);
    bus.nmi = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst.NMI",  32'(bus.NMI),  32'd0);
    check("post_rst.busy", 32'(bus.busy), 32'd0);
    $display("post reset: NMI=%0b busy=%0b", bus.NMI, bus.busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sits between external interrupt sources and the multi-cycle processor's Controller.
- Masks and prioritises NUM_IRQ maskable lines plus one NMI, then drives the Controller's INT/NMI request pins.
- Completes the INA (acknowledge) / INTD (done) handshake and supplies the vector id and address the datapath loads into PC.
- Allows one level of NMI pre-emption over a maskable interrupt in service.

Parameters:
- NUM_IRQ, 8: number of maskable request lines; 1..16.
- VEC_BASE, 32'h0000_0080: vector address of irq 0.
- VEC_STRIDE, 32'h10: byte spacing between vectors.
- NMI_VEC, 32'h0000_0040: NMI vector address.
- MASK_RST, all ones: mask value after reset (1 = enabled).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  NUM_IRQ  maskable requests, level-sensitive, synchronous to clk.
- nmi  in  1  non-maskable request, rising-edge-sensitive.
- mask_we  in  1  load mask register.
- mask_wdata  in  NUM_IRQ  new mask value.
- INT  out  1  maskable request to Controller.
- NMI  out  1  NMI request to Controller.
- INA  in  1  Controller acknowledge, 1-cycle pulse, taken at an instruction boundary.
- INTD  in  1  Controller return-from-interrupt, 1-cycle pulse.
- vec_id  out  $clog2(NUM_IRQ)  id of the active or pending irq.
- vec_addr  out  32  vector for PC load: NMI_VEC in NMI states, else VEC_BASE + vec_id*VEC_STRIDE.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset state: IDLE, INT=0, NMI=0, vec_id=0, busy=0, mask=MASK_RST, nmi_pend=0, nested=0. Reset applies immediately, including mid-handshake.
- pend = irq & mask. sel = lowest set index of pend; index 0 has highest priority.
- nmi_pend is set on an nmi rising edge, using a registered previous sample. It is cleared when INA is taken in NREQ.
- All outputs are registered; request latency is 1 cycle (source sampled at edge k gives INT/NMI high after edge k).
- State IDLE:
  - nmi_pend → NREQ.
  - Otherwise, pend != 0 → REQ and latch vec_id = sel.
- State REQ (INT=1):
  - INA → SERV, INT=0.
  - nmi_pend with no INA → NREQ; INT drops and the irq is re-arbitrated later.
  - pend[vec_id] drops (source released or masked) with no INA → IDLE and INT=0 (withdraw).
  - A higher-priority pend arriving while in REQ updates vec_id. INA in that same cycle acknowledges the old vec_id.
- State SERV:
  - INTD → IDLE.
  - nmi_pend → NREQ with nested=1.
  - INTD and nmi_pend in the same cycle → IDLE takes precedence; the NMI is served next cycle.
- State NREQ (NMI=1): INA → NSERV, NMI=0. NMI is never withdrawn.
- State NSERV: INTD → SERV if nested, else IDLE; nested is cleared.
- A second nmi edge during NSERV is latched and served after return.
- INA or INTD outside the states that expect them is ignored.
- mask_we takes effect the next cycle; it never aborts SERV or NSERV.
- The irq in service is not re-requested until INTD, even if still asserted. Re-request then follows IDLE rules (≥1 IDLE cycle).

Optional Feature:
- Macro IRQ_EDGE_EN.
- Defined: each irq line has a sticky pending bit set on a rising edge and cleared by INA for that id.
  - pend = sticky & mask.
  - REQ withdrawal happens only when the mask bit clears.
- Undefined: level-sensitive behaviour exactly as described above; no sticky bits.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum (IDLE, REQ, SERV, NREQ, NSERV);
  - VEC_BASE / NMI_VEC / VEC_STRIDE defaults;
  - IRQ_ID_W helper function.
- One sub-module, irq_prio_enc: combinational lowest-index priority encoder (pend → sel, any).

Test Plan:
- irq=8'b0010_0100, mask all ones → INT=1 one cycle later, vec_id=2, vec_addr=0xA0. INA pulse → INT=0, busy=1. INTD → IDLE, then irq 2 is re-requested.
- irq[3] high, mask_we with mask[3]=0 while in REQ → INT falls next cycle, state IDLE, no INA expected.
- SERV on irq 1, then nmi edge → NMI=1, vec_addr=0x40. INA then INTD → back to SERV with vec_id=1 and busy=1. INTD → IDLE.
- INTD and nmi edge in the same cycle during SERV → IDLE for one cycle, then NMI=1.
- Assert rst asynchronously while in NREQ → NMI=0, busy=0, mask=MASK_RST immediately, without waiting for a clock edge.
- IRQ_EDGE_EN: 1-cycle pulse on irq[5] → INT=1 and held until INA, vec_id=5. Same test without the macro → request withdrawn (INT drops after the pulse ends).
